// File: rtl/mem_wb_skid_pkg.sv
// Shared word/register-file widths plus the types used by the MEM->WB skid stage.
`ifndef MEM_WB_SKID_DEFINES
`define MEM_WB_SKID_DEFINES
`define WORD_WIDTH 32
`define REG_SIZE   32
`define ZERO_WORD  32'h0000_0000
`endif

package mem_wb_skid_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    // Packed entry is {we, waddr, rdata, alu}.
    function automatic int payload_width(input int data_w, input int addr_w);
        return 1 + addr_w + 2 * data_w;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry skid buffer: main register drives the output, skid catches the one
// entry accepted after out_ready drops; in_ready is registered.
module pipe_skid_buf
    import mem_wb_skid_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] FLUSH_CLR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             skid_full
);

    skid_state_e      state_q;
    skid_state_e      state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             ready_q;
    logic             in_fire;
    logic             out_fire;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;

    assign in_fire   = in_valid & ready_q;
    assign out_fire  = (state_q != SKID_EMPTY) & out_ready;
    assign in_ready  = ready_q;
    assign out_valid = (state_q != SKID_EMPTY);
    assign skid_full = (state_q == SKID_FULL);
    assign out_data  = main_q;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (in_fire) begin
                        load_main = 1'b1;
                        state_d   = SKID_BUSY;
                    end
                end
                SKID_BUSY: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (in_fire) begin
                        load_skid = 1'b1;
                        state_d   = SKID_FULL;
                    end else if (out_fire) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (out_fire) begin
                        main_from_skid = 1'b1;
                        state_d        = SKID_BUSY;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    // Flush only masks the FLUSH_CLR bits of held entries; loads never coincide with flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SKID_EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != SKID_FULL);
            if (load_main)
                main_q <= in_data;
            else if (main_from_skid)
                main_q <= skid_q;
            else if (flush)
                main_q <= main_q & ~FLUSH_CLR;
            if (load_skid)
                skid_q <= in_data;
            else if (flush)
                skid_q <= skid_q & ~FLUSH_CLR;
        end
    end

endmodule

// File: rtl/mem_wb_skid.sv
// MEM->WB stage register: packs the entry, drops writes to r0 at capture and hides
// out_we whenever nothing is presented.
module mem_wb_skid
    import mem_wb_skid_pkg::*;
#(
    parameter int DATA_W = `WORD_WIDTH,
    parameter int ADDR_W = $clog2(`REG_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_we,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_rdata,
    input  logic [ADDR_W-1:0] in_waddr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_we,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_rdata,
    output logic [ADDR_W-1:0] out_waddr,
    output logic              skid_full
);

    localparam int PW = payload_width(DATA_W, ADDR_W);
    localparam logic [PW-1:0] WE_MASK = {1'b1, {(PW-1){1'b0}}};

    logic          we_clean;
    logic          stored_we;
    logic [PW-1:0] in_pack;
    logic [PW-1:0] out_pack;

    assign we_clean = in_we & (in_waddr != '0);
    assign in_pack  = {we_clean, in_waddr, in_rdata, in_alu};

    pipe_skid_buf #(
        .WIDTH    (PW),
        .FLUSH_CLR(WE_MASK)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_pack),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_pack),
        .skid_full(skid_full)
    );

    assign {stored_we, out_waddr, out_rdata, out_alu} = out_pack;
    assign out_we = out_valid & stored_we;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Bench for mem_wb_skid: a directed vector table for the named corner cases, then
// random traffic checked against a queue-based model of the stage.
module tb_mem_wb_skid;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, in_we;
    logic [DW-1:0] in_alu, in_rdata;
    logic [AW-1:0] in_waddr;
    logic          out_valid, out_ready, out_we, skid_full;
    logic [DW-1:0] out_alu, out_rdata;
    logic [AW-1:0] out_waddr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_wb_skid #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we),
        .in_alu(in_alu), .in_rdata(in_rdata), .in_waddr(in_waddr),
        .out_valid(out_valid), .out_ready(out_ready), .out_we(out_we),
        .out_alu(out_alu), .out_rdata(out_rdata), .out_waddr(out_waddr),
        .skid_full(skid_full)
    );

    typedef struct {
        logic          rst, flush, iv, we;
        logic [AW-1:0] wa;
        logic [DW-1:0] alu;
        logic          ordy;
        logic          eov, erdy, eskf, ewe;
        logic [DW-1:0] ealu;
    } vec_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] rd;
        logic [DW-1:0] alu;
    } ent_t;

    vec_t vecs[$];
    ent_t q[$];
    ent_t shadow;
    bit   mRdy;

    function automatic void addVec(int r, int f, int iv, int we, int wa, int alu, int ordy,
                                   int eov, int erdy, int eskf, int ewe, int ealu);
        vec_t v;
        v.rst = r[0];  v.flush = f[0]; v.iv = iv[0]; v.we = we[0];
        v.wa = AW'(wa); v.alu = DW'(alu); v.ordy = ordy[0];
        v.eov = eov[0]; v.erdy = erdy[0]; v.eskf = eskf[0]; v.ewe = ewe[0];
        v.ealu = DW'(ealu);
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic applyStimulus(input logic r, input logic f, input logic v, input logic we,
                                 input logic [AW-1:0] wa, input logic [DW-1:0] alu,
                                 input logic [DW-1:0] rd, input logic ordy);
        @(negedge clk);
        rst = r; flush = f; in_valid = v; in_we = we;
        in_waddr = wa; in_alu = alu; in_rdata = rd; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_we = 1'b0;
        in_waddr = '0; in_alu = '0; in_rdata = '0; out_ready = 1'b0;

        //     rst f iv we wa alu     ordy | ov rdy skf we alu
        addVec(1, 0, 1, 1, 3, 'h99,   1,    0, 1, 0, 0, 'h0);
        addVec(1, 0, 1, 1, 3, 'h99,   1,    0, 1, 0, 0, 'h0);
        addVec(0, 0, 1, 1, 3, 'h10,   1,    1, 1, 0, 1, 'h10);
        addVec(0, 0, 1, 1, 3, 'h11,   1,    1, 1, 0, 1, 'h11);
        addVec(0, 0, 1, 1, 3, 'h12,   1,    1, 1, 0, 1, 'h12);
        addVec(0, 0, 0, 0, 0, 'h0,    1,    0, 1, 0, 0, 'h12);
        addVec(0, 0, 1, 1, 4, 'hA,    1,    1, 1, 0, 1, 'hA);
        addVec(0, 0, 1, 1, 4, 'hB,    0,    1, 0, 1, 1, 'hA);
        addVec(0, 0, 1, 1, 4, 'h77,   0,    1, 0, 1, 1, 'hA);
        addVec(0, 0, 0, 0, 0, 'h0,    1,    1, 1, 0, 1, 'hB);
        addVec(0, 0, 0, 0, 0, 'h0,    1,    0, 1, 0, 0, 'hB);
        addVec(0, 0, 1, 1, 0, 'hDEAD, 0,    1, 1, 0, 0, 'hDEAD);
        addVec(0, 0, 0, 0, 0, 'h0,    1,    0, 1, 0, 0, 'hDEAD);
        addVec(0, 0, 1, 1, 5, 'h21,   0,    1, 1, 0, 1, 'h21);
        addVec(0, 0, 1, 1, 5, 'h22,   0,    1, 0, 1, 1, 'h21);
        addVec(0, 1, 1, 1, 5, 'hC,    0,    0, 1, 0, 0, 'h21);
        addVec(0, 0, 0, 0, 0, 'h0,    1,    0, 1, 0, 0, 'h21);
        addVec(0, 0, 1, 1, 3, 'h31,   0,    1, 1, 0, 1, 'h31);
        addVec(1, 0, 1, 1, 3, 'h32,   0,    0, 1, 0, 0, 'h0);
        addVec(0, 0, 0, 0, 0, 'h0,    1,    0, 1, 0, 0, 'h0);
        addVec(0, 0, 1, 1, 3, 'hD0,   1,    1, 1, 0, 1, 'hD0);
        addVec(0, 0, 0, 0, 0, 'h0,    1,    0, 1, 0, 0, 'hD0);
        addVec(0, 0, 1, 0, 7, 'h41,   0,    1, 1, 0, 0, 'h41);
        addVec(0, 1, 1, 1, 7, 'h42,   1,    0, 1, 0, 0, 'h41);
        addVec(0, 0, 0, 0, 0, 'h0,    1,    0, 1, 0, 0, 'h41);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].we, vecs[i].wa,
                          vecs[i].alu, ~vecs[i].alu, vecs[i].ordy);
            checkOutput($sformatf("vec%0d out_valid", i), DW'(out_valid), DW'(vecs[i].eov));
            checkOutput($sformatf("vec%0d in_ready",  i), DW'(in_ready),  DW'(vecs[i].erdy));
            checkOutput($sformatf("vec%0d skid_full", i), DW'(skid_full), DW'(vecs[i].eskf));
            checkOutput($sformatf("vec%0d out_we",    i), DW'(out_we),    DW'(vecs[i].ewe));
            checkOutput($sformatf("vec%0d out_alu",   i), out_alu,        vecs[i].ealu);
        end

        // The model keeps the accepted entries in order; the main register shows the head,
        // or the last head once everything has drained.
        for (int c = 0; c < 3000; c++) begin
            logic r, f, v, we, ordy, inFire, outFire;
            logic [AW-1:0] wa;
            logic [DW-1:0] alu, rd;
            ent_t e;
            r    = (c == 0) || ($urandom_range(0, 63) == 0);
            f    = ($urandom_range(0, 31) == 0);
            v    = ($urandom_range(0, 9) < 7);
            we   = ($urandom_range(0, 3) != 0);
            wa   = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
            alu  = $urandom;
            rd   = $urandom;
            ordy = ($urandom_range(0, 9) < 6);
            inFire  = v && mRdy;
            outFire = (q.size() > 0) && ordy;
            applyStimulus(r, f, v, we, wa, alu, rd, ordy);
            if (r) begin
                q.delete();
                mRdy   = 1'b1;
                shadow = '0;
            end else if (f) begin
                q.delete();
                mRdy      = 1'b1;
                shadow.we = 1'b0;
            end else begin
                if (outFire) void'(q.pop_front());
                if (inFire) begin
                    e.we = we && (wa != 0); e.wa = wa; e.rd = rd; e.alu = alu;
                    q.push_back(e);
                end
                mRdy = (q.size() < 2);
            end
            if (q.size() > 0) shadow = q[0];
            checkOutput("rnd out_valid", DW'(out_valid), DW'(q.size() > 0));
            checkOutput("rnd in_ready",  DW'(in_ready),  DW'(mRdy));
            checkOutput("rnd skid_full", DW'(skid_full), DW'(q.size() == 2));
            checkOutput("rnd out_we",    DW'(out_we),    DW'((q.size() > 0) && shadow.we));
            checkOutput("rnd out_alu",   out_alu,        shadow.alu);
            checkOutput("rnd out_rdata", out_rdata,      shadow.rd);
            checkOutput("rnd out_waddr", DW'(out_waddr), DW'(shadow.wa));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_skid.md
# mem_wb_skid

Parametrised MEM→WB pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and write-enable sanitising. It sits between the memory stage and the register-file write-back port. It replaces the plain always-enabled stage register so that back-pressure from write-back (for example, regfile port arbitration) stalls cleanly. No combinational path runs from `out_ready` to `in_ready`.

## Interface
- `DATA_W`, default 32: width of the ALU result and the load data.
- `ADDR_W`, default 5: width of the destination register address.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `flush` in 1: synchronous pipeline flush; discards all held and incoming entries.
- `in_valid` in 1: the MEM stage presents an entry.
- `in_ready` out 1: the block can accept an entry; registered.
- `in_we` in 1: register-file write enable of the entry.
- `in_alu` in DATA_W: ALU result.
- `in_rdata` in DATA_W: memory read data.
- `in_waddr` in ADDR_W: destination register.
- `out_valid` out 1: an entry is presented to WB.
- `out_ready` in 1: WB consumes the entry.
- `out_we`, `out_alu`, `out_rdata`, `out_waddr` out: the presented entry.
- `skid_full` out 1: status; the skid entry is occupied.

## Operation
- Transfer rules:
  - Input fire = `in_valid & in_ready`.
  - Output fire = `out_valid & out_ready`.
- Storage:
  - Main register drives the `out_*` ports.
  - Skid register holds one overflow entry.
- State machine, 2-bit:
  - EMPTY: main and skid both empty. `in_ready`=1. Input fire loads main and moves to BUSY.
  - BUSY: main valid, skid empty. `in_ready`=1.
    - Input fire and output fire: main loads the new entry; stay in BUSY.
    - Input fire without output fire: the new entry goes to skid; move to FULL.
    - Output fire without input fire: move to EMPTY.
    - Neither: hold.
  - FULL: main and skid both valid. `in_ready`=0. Output fire copies skid into main and moves to BUSY; otherwise hold.
- `in_ready` is registered: it is 1 in the next cycle if and only if the next state is not FULL.
- `out_valid` = state is not EMPTY. `skid_full` = state is FULL.
- Write-enable sanitising, applied at capture: the stored `we` = `in_we & (in_waddr != 0)`. Entries with `we`=0 still flow through and still handshake.
- Priority order: `rst` > `flush` > normal operation.
- Flush:
  - Next state is EMPTY and `in_ready` goes to 1.
  - Any entry offered in the flush cycle is dropped.
  - The stored `we` bits of main and skid are cleared.
- Payload registers load only on capture. They are not cleared when an entry leaves.
- While `out_valid`=0, `out_we` is forced to 0.

## Timing
- Reset: state EMPTY; `out_valid`=0, `out_we`=0, `out_alu`/`out_rdata`=0, `out_waddr`=0, `skid_full`=0, `in_ready`=1 from the first edge in reset onward. Entries offered while `rst`=1 are dropped.
- Latency: 1 cycle. An input fire at edge N makes the entry visible on `out_*` after edge N with `out_valid`=1.
- Throughput: 1 entry per cycle while `out_ready` stays high.
- When `out_ready` drops, at most one extra entry is accepted, into skid, because `in_ready` is registered. Nothing is lost and nothing is duplicated.
- Order is strictly FIFO: main then skid.
- Reset or flush in FULL discards both entries. The next cycle shows `out_valid`=0 and `in_ready`=1.
- A simultaneous input fire and output fire in BUSY never passes through FULL.

## Structure
- Shared defines file holds `` `WORD_WIDTH ``, `` `REG_SIZE `` and `` `ZERO_WORD ``. The default parameters derive from them.
- Payload packing lives in this block: `{we, waddr, rdata, alu}`, width = 1+ADDR_W+2·DATA_W.
- One sub-module is natural: `pipe_skid_buf`, parameter WIDTH. It is a generic 2-entry skid buffer containing the FSM, the `in_ready` register and flush.
- `mem_wb_skid` is the pack/unpack wrapper around it, plus the `we` sanitising and the `out_we` gating.
- `pipe_skid_buf` is reused later for the IF/ID and ID/EX stages.

## Test plan
- Streaming:
  - Stimulus: after reset, `out_ready`=1; send alu=0x10,0x11,0x12 with waddr=3, `we`=1 on consecutive cycles.
  - Expected: each entry appears one cycle later, back-to-back; `in_ready` stays 1.
- Back-pressure:
  - Stimulus: send A(alu=0xA) and B(alu=0xB); drop `out_ready` in the cycle A is presented.
  - Expected: B lands in skid; `skid_full`=1; `in_ready`=0 next cycle.
  - Stimulus: raise `out_ready` for two cycles.
  - Expected: A then B delivered; state returns to EMPTY.
- r0 suppression:
  - Stimulus: `in_we`=1 with `in_waddr`=0, alu=0xDEAD.
  - Expected: `out_valid`=1, `out_alu`=0xDEAD, `out_we`=0.
- Flush in FULL:
  - Stimulus: fill main and skid; assert `flush` together with a new input C.
  - Expected: next cycle `out_valid`=0, `out_we`=0, `in_ready`=1; C is never emitted.
- Reset mid-stream:
  - Stimulus: `rst` in BUSY with `in_valid`=1.
  - Expected: all outputs return to their reset values; the entry offered during reset never appears.
  - Stimulus: a subsequent entry D.
  - Expected: D passes with 1-cycle latency.
